// File: rtl/bus_pack_pkg.sv
// Shared primitives for bus_pack: architecture selector strings, the clog2
// helper used to size the lane counter, and the two-state packer FSM enum.
// No logic; imported by the interface and the top.
package bus_pack_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    PACK      = 1'b1
  } state_t;

  // Ceiling log2, with a minimum of 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_pack_if.sv
// Narrow-in / wide-out bus between the slice stage and bus_pack.
// master: upstream side driving narrow words, observing the packed output.
// slave : bus_pack side consuming narrow words and driving the packed word.
interface bus_pack_if #(
  parameter int W = 8,
  parameter int P = 4
);
  import bus_pack_pkg::*;

  logic [W-1:0]   data_in;
  logic           valid_in;
  logic           sync_in;
  logic [W*P-1:0] data_out;
  logic           valid_out;
  logic           sync_out;
  logic           drop_out;

  modport master (
    output data_in, valid_in, sync_in,
    input  data_out, valid_out, sync_out, drop_out
  );

  modport slave (
    input  data_in, valid_in, sync_in,
    output data_out, valid_out, sync_out, drop_out
  );

endinterface

// File: rtl/bus_pack.sv
// Packs PACK_FACTOR consecutive accepted narrow words into one registered wide word.
// Ports: clk, rst_n (async active-low), bus (slave modport: data/valid/sync in;
//   data/valid/sync/drop out). Output registered, valid_out one clock after the
//   last word; no backpressure, gaps in valid_in simply stall the lane counter.
module bus_pack
  import bus_pack_pkg::*;
#(
  parameter string BLOCK_NAME       = "bus_pack",
  parameter int    X                = 0,
  parameter int    Y                = 0,
  parameter int    DX               = 0,
  parameter int    DY               = 0,
  parameter string ARCHITECTURE     = "BEHAVIORAL",
  parameter int    INPUT_DATA_WIDTH = 8,
  parameter int    PACK_FACTOR      = 4,
  parameter int    FIRST_IN_MSB     = 1,
  parameter int    REQUIRE_SYNC     = 1
) (
  input logic       clk,
  input logic       rst_n,
  bus_pack_if.slave bus
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int P  = PACK_FACTOR;
  localparam int OW = W * P;
  localparam int CW = clog2(P);
  localparam logic [CW-1:0] LAST_SLOT = CW'(P - 1);

  // Elaboration-time parameter sanity; placement values are diagram-only.
  if (W < 1 || P < 2) begin : g_bad_size
    $error("bus_pack: INPUT_DATA_WIDTH must be >= 1 and PACK_FACTOR >= 2");
  end
  if (X < 0 || Y < 0 || DX < 0 || DY < 0 || BLOCK_NAME == "") begin : g_bad_diagram
    $error("bus_pack: diagram placement must be non-negative and named");
  end

  if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   hold_q, hold_d;      // slot k lives at [k*W +: W]
    logic            sync_pend_q, sync_pend_d;
    logic [OW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            sync_q, sync_d;
    logic            drop_q, drop_d;
    logic            qual_sync;
    logic            accept;

    always_comb begin
      qual_sync   = bus.valid_in && bus.sync_in;
      accept      = bus.valid_in && (state_q == PACK);
      state_d     = state_q;
      count_d     = count_q;
      hold_d      = hold_q;
      sync_pend_d = sync_pend_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      sync_d      = 1'b0;
      drop_d      = 1'b0;

      if (qual_sync) begin
        // A sync always restarts the word, even on what would have been the
        // completing slot; any partial word in flight is abandoned.
        state_d     = PACK;
        hold_d[W-1:0] = bus.data_in;
        count_d     = CW'(1);
        sync_pend_d = 1'b1;
        drop_d      = (state_q == PACK) && (count_q != '0);
      end else if (accept) begin
        hold_d[int'(count_q)*W +: W] = bus.data_in;
        if (count_q == LAST_SLOT) begin
          count_d     = '0;
          valid_d     = 1'b1;
          sync_d      = sync_pend_q;
          sync_pend_d = 1'b0;
          // hold_d already carries the current word in the last slot.
          for (int k = 0; k < P; k++) begin
            if (FIRST_IN_MSB != 0) data_d[(P-1-k)*W +: W] = hold_d[k*W +: W];
            else                   data_d[k*W +: W]       = hold_d[k*W +: W];
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= (REQUIRE_SYNC != 0) ? WAIT_SYNC : PACK;
        count_q     <= '0;
        hold_q      <= '0;
        sync_pend_q <= 1'b0;
        data_q      <= '0;
        valid_q     <= 1'b0;
        sync_q      <= 1'b0;
        drop_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        count_q     <= count_d;
        hold_q      <= hold_d;
        sync_pend_q <= sync_pend_d;
        data_q      <= data_d;
        valid_q     <= valid_d;
        sync_q      <= sync_d;
        drop_q      <= drop_d;
      end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.sync_out  = sync_q;
    assign bus.drop_out  = drop_q;

  end else if (ARCHITECTURE == ARCH_VIRTEX5) begin : g_virtex5
  end else if (ARCHITECTURE == ARCH_VIRTEX6) begin : g_virtex6
  end

endmodule

// File: tb/tb_bus_pack.sv
module tb_bus_pack;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       vin;
  logic       sin;

  int checks;
  int failures;

  bus_pack_if #(.W(8), .P(4)) if_a ();  // REQUIRE_SYNC=0, MSB first
  bus_pack_if #(.W(8), .P(4)) if_b ();  // REQUIRE_SYNC=0, LSB first
  bus_pack_if #(.W(8), .P(4)) if_c ();  // REQUIRE_SYNC=1, MSB first

  assign if_a.data_in = din; assign if_a.valid_in = vin; assign if_a.sync_in = sin;
  assign if_b.data_in = din; assign if_b.valid_in = vin; assign if_b.sync_in = sin;
  assign if_c.data_in = din; assign if_c.valid_in = vin; assign if_c.sync_in = sin;

  bus_pack #(.INPUT_DATA_WIDTH(8), .PACK_FACTOR(4), .FIRST_IN_MSB(1), .REQUIRE_SYNC(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bus_pack #(.INPUT_DATA_WIDTH(8), .PACK_FACTOR(4), .FIRST_IN_MSB(0), .REQUIRE_SYNC(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bus_pack #(.INPUT_DATA_WIDTH(8), .PACK_FACTOR(4), .FIRST_IN_MSB(1), .REQUIRE_SYNC(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one input cycle, then sample 1ns after the capturing edge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    din = d; vin = v; sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    din = 8'h00; vin = 1'b0; sin = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({if_a.data_out, if_b.data_out, if_c.data_out} !== 96'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", if_a.data_out, if_b.data_out, if_c.data_out);
    end
    checks++;
    if ({if_a.valid_out, if_a.sync_out, if_a.drop_out, if_c.valid_out, if_c.sync_out, if_c.drop_out} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got a=%b%b%b c=%b%b%b exp=0", if_a.valid_out, if_a.sync_out,
                           if_a.drop_out, if_c.valid_out, if_c.sync_out, if_c.drop_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_lane_order();
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    checks++;
    if (if_a.valid_out !== 1'b0) begin
      failures++; $display("FAIL lane_early_valid got=%b exp=0", if_a.valid_out);
    end
    cyc(1'b1, 1'b0, 8'h44);
    checks++;
    if (if_a.valid_out !== 1'b1 || if_a.data_out !== 32'h11223344) begin
      failures++; $display("FAIL lane_msb got v=%b d=%h exp v=1 d=11223344", if_a.valid_out, if_a.data_out);
    end
    checks++;
    if (if_b.valid_out !== 1'b1 || if_b.data_out !== 32'h44332211) begin
      failures++; $display("FAIL lane_lsb got v=%b d=%h exp v=1 d=44332211", if_b.valid_out, if_b.data_out);
    end
    checks++;
    if (if_c.valid_out !== 1'b0) begin
      failures++; $display("FAIL lane_nosync_gated got=%b exp=0", if_c.valid_out);
    end
    cyc(1'b0, 1'b0, 8'h00);
    checks++;
    if (if_a.valid_out !== 1'b0 || if_a.data_out !== 32'h11223344) begin
      failures++; $display("FAIL lane_hold got v=%b d=%h exp v=0 d=11223344", if_a.valid_out, if_a.data_out);
    end
  endtask

  task automatic test_sync_gating();
    int early;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'hAA);
      if (if_c.valid_out !== 1'b0 || if_c.drop_out !== 1'b0) early++;
    end
    // sync with valid_in low must be ignored
    cyc(1'b0, 1'b1, 8'hEE);
    if (if_c.valid_out !== 1'b0 || if_c.drop_out !== 1'b0) early++;
    cyc(1'b1, 1'b1, 8'h01);
    checks++;
    if (if_c.drop_out !== 1'b0) begin
      failures++; $display("FAIL gate_no_drop_from_wait got=%b exp=0", if_c.drop_out);
    end
    // dut_a had three words pending: sync on the completing slot wins
    checks++;
    if (if_a.drop_out !== 1'b1 || if_a.valid_out !== 1'b0) begin
      failures++; $display("FAIL sync_on_last_slot got drop=%b v=%b exp drop=1 v=0", if_a.drop_out, if_a.valid_out);
    end
    cyc(1'b1, 1'b0, 8'h02);
    if (if_c.valid_out !== 1'b0) early++;
    cyc(1'b1, 1'b0, 8'h03);
    if (if_c.valid_out !== 1'b0) early++;
    checks++;
    if (early !== 0) begin
      failures++; $display("FAIL gate_early_output got=%0d exp=0", early);
    end
    cyc(1'b1, 1'b0, 8'h04);
    checks++;
    if (if_c.valid_out !== 1'b1 || if_c.data_out !== 32'h01020304 || if_c.sync_out !== 1'b1) begin
      failures++; $display("FAIL gate_first_word got v=%b s=%b d=%h exp v=1 s=1 d=01020304",
                           if_c.valid_out, if_c.sync_out, if_c.data_out);
    end
    checks++;
    if (if_a.valid_out !== 1'b1 || if_a.data_out !== 32'h01020304 || if_a.sync_out !== 1'b1) begin
      failures++; $display("FAIL resync_after_last_slot got v=%b s=%b d=%h exp v=1 s=1 d=01020304",
                           if_a.valid_out, if_a.sync_out, if_a.data_out);
    end
  endtask

  task automatic test_stalls();
    logic [31:0] exp_words [2];
    int nout;
    exp_words[0] = 32'h10111213;
    exp_words[1] = 32'h14151617;
    nout = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < (k % 4); g++) begin
        cyc(1'b0, 1'b0, 8'hFF);
        if (if_c.valid_out === 1'b1) nout++;
      end
      cyc(1'b1, 1'b0, 8'h10 + 8'(k));
      if (if_c.valid_out === 1'b1) begin
        checks++;
        if (nout > 1 || if_c.data_out !== exp_words[nout] || if_c.sync_out !== 1'b0) begin
          failures++; $display("FAIL stall_word%0d got d=%h s=%b exp d=%h s=0", nout, if_c.data_out,
                               if_c.sync_out, exp_words[nout > 1 ? 1 : nout]);
        end
        nout++;
      end
    end
    checks++;
    if (nout !== 2) begin
      failures++; $display("FAIL stall_count got=%0d exp=2", nout);
    end
  endtask

  task automatic test_resync();
    cyc(1'b1, 1'b0, 8'h61);
    cyc(1'b1, 1'b0, 8'h62);
    cyc(1'b1, 1'b1, 8'h55);
    checks++;
    if (if_c.drop_out !== 1'b1 || if_c.valid_out !== 1'b0) begin
      failures++; $display("FAIL resync_drop got drop=%b v=%b exp drop=1 v=0", if_c.drop_out, if_c.valid_out);
    end
    cyc(1'b1, 1'b0, 8'h56);
    checks++;
    if (if_c.drop_out !== 1'b0) begin
      failures++; $display("FAIL resync_drop_pulse got=%b exp=0", if_c.drop_out);
    end
    cyc(1'b1, 1'b0, 8'h57);
    cyc(1'b1, 1'b0, 8'h58);
    checks++;
    if (if_c.valid_out !== 1'b1 || if_c.data_out !== 32'h55565758 || if_c.sync_out !== 1'b1) begin
      failures++; $display("FAIL resync_word got v=%b s=%b d=%h exp v=1 s=1 d=55565758",
                           if_c.valid_out, if_c.sync_out, if_c.data_out);
    end
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    cyc(1'b1, 1'b0, 8'h04);
    checks++;
    if (if_c.valid_out !== 1'b1 || if_c.data_out !== 32'h01020304 || if_c.sync_out !== 1'b0) begin
      failures++; $display("FAIL resync_next_nosync got v=%b s=%b d=%h exp v=1 s=0 d=01020304",
                           if_c.valid_out, if_c.sync_out, if_c.data_out);
    end
  endtask

  task automatic test_reset_mid();
    int drops;
    drops = 0;
    cyc(1'b1, 1'b0, 8'h71);
    cyc(1'b1, 1'b0, 8'h72);
    din = 8'h00; vin = 1'b0; sin = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.data_out !== 32'h0 || if_a.valid_out !== 1'b0 || if_a.sync_out !== 1'b0 ||
        if_a.drop_out !== 1'b0 || if_c.data_out !== 32'h0) begin
      failures++; $display("FAIL midreset_outputs got a=%h %b%b%b c=%h exp 0", if_a.data_out,
                           if_a.valid_out, if_a.sync_out, if_a.drop_out, if_c.data_out);
    end
    #3;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h81);
    if (if_a.drop_out !== 1'b0) drops++;
    cyc(1'b1, 1'b0, 8'h82);
    if (if_a.drop_out !== 1'b0) drops++;
    cyc(1'b1, 1'b0, 8'h83);
    if (if_a.drop_out !== 1'b0) drops++;
    cyc(1'b1, 1'b0, 8'h84);
    if (if_a.drop_out !== 1'b0) drops++;
    checks++;
    if (if_a.valid_out !== 1'b1 || if_a.data_out !== 32'h81828384 || drops !== 0) begin
      failures++; $display("FAIL midreset_clean_word got v=%b d=%h drops=%0d exp v=1 d=81828384 drops=0",
                           if_a.valid_out, if_a.data_out, drops);
    end
    checks++;
    if (if_c.valid_out !== 1'b0) begin
      failures++; $display("FAIL midreset_wait_sync got=%b exp=0", if_c.valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  grp [4];
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
    logic [7:0]  d;
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom_range(0, 255));
      grp[i % 4] = d;
      cyc(1'b1, 1'b0, d);
      checks++;
      if (if_a.valid_out !== ((i % 4) == 3) || if_a.drop_out !== 1'b0) begin
        failures++; $display("FAIL b2b_valid[%0d] got v=%b drop=%b exp v=%b drop=0", i, if_a.valid_out,
                             if_a.drop_out, (i % 4) == 3);
      end
      if ((i % 4) == 3) begin
        exp_msb = {grp[0], grp[1], grp[2], grp[3]};
        exp_lsb = {grp[3], grp[2], grp[1], grp[0]};
        checks++;
        if (if_a.data_out !== exp_msb || if_b.data_out !== exp_lsb) begin
          failures++; $display("FAIL b2b_data[%0d] got a=%h b=%h exp a=%h b=%h", i, if_a.data_out,
                               if_b.data_out, exp_msb, exp_lsb);
        end
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    din = 8'h00; vin = 1'b0; sin = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_lane_order();
    test_sync_gating();
    test_stalls();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
